brq_clint: RTL

BRQ_CLINT -- requirements
Module: brq_clint

---
 rtl/brq_clint.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/brq_clint.sv
// ---------------------------------------------------------------------------
// brq_clint -- core-local interruptor: machine timer (mtime/mtimecmp) and
// machine software interrupt (MSIP) behind a 32-byte register window.
//
// Register map (byte offsets from BaseAddr, word accesses only):
//   0x00 MSIP         bit0 only, other bits read 0
//   0x08 MTIMECMP_LO
//   0x0C MTIMECMP_HI
//   0x10 MTIME_LO     reading it snapshots mtime[63:32] into a shadow
//   0x14 MTIME_HI     returns the shadow captured by the last LO read
//   0x18 PRESCALE     bits 15:0, only with BRQ_CLINT_PRESCALER_EN
//   anything else in or outside the window -> error response
//
// Build option:
//   BRQ_CLINT_PRESCALER_EN  defined  : mtime advances once every
//                                      PRESCALE+1 cycles (tick counter).
//                           undefined: mtime advances every cycle and
//                                      offset 0x18 is an error.
//
// Ports:
//   clk_i           single clock
//   rst_i           synchronous active-high reset
//   data_req_i      request valid (always granted, no backpressure)
//   data_we_i       1 = write, 0 = read
//   data_be_i       byte enables for writes
//   data_addr_i     byte address
//   data_wdata_i    write data
//   data_gnt_o      grant, combinationally equal to data_req_i
//   data_rvalid_o   response valid, one cycle after each accepted request
//   data_rdata_o    read data (0 for writes and errors)
//   data_err_o      response error
//   irq_software_o  machine software interrupt (MSIP bit0)
//   irq_timer_o     machine timer interrupt, registered mtime >= mtimecmp
// ---------------------------------------------------------------------------
module brq_clint #(
    parameter logic [31:0] BaseAddr = 32'h0200_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        irq_software_o,
    output logic        irq_timer_o
);

    localparam logic [4:0] OffMsip      = 5'h00;
    localparam logic [4:0] OffMtimecmpL = 5'h08;
    localparam logic [4:0] OffMtimecmpH = 5'h0C;
    localparam logic [4:0] OffMtimeL    = 5'h10;
    localparam logic [4:0] OffMtimeH    = 5'h14;
`ifdef BRQ_CLINT_PRESCALER_EN
    localparam logic [4:0] OffPrescale  = 5'h18;
`endif

    // Byte-lane merge: lanes with be=1 take the new byte, others keep the old.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // -----------------------------------------------------------------
    // State
    // -----------------------------------------------------------------
    logic        rvalid_r;
    logic        err_r;
    logic [31:0] rdata_r;
    logic        msip_r;
    logic [63:0] mtimecmp_r;
    logic [63:0] mtime_r;
    logic [31:0] shadow_r;
    logic        irq_timer_r;

    // -----------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------
    logic [31:0] offset_s;
    logic        in_window_s;
    logic        acc_err_s;
    logic        sel_msip_s;
    logic        sel_cmp_lo_s;
    logic        sel_cmp_hi_s;
    logic        sel_mtime_lo_s;
    logic        sel_mtime_hi_s;
`ifdef BRQ_CLINT_PRESCALER_EN
    logic        sel_prescale_s;
`endif
    logic        valid_s;
    logic        wr_s;
    logic        rd_s;
    logic [31:0] rd_data_s;
    logic        tick_s;
    logic [63:0] mtime_nxt_s;

    // An address below BaseAddr wraps to a huge offset, so one unsigned
    // compare covers both sides of the window.
    assign offset_s    = data_addr_i - BaseAddr;
    assign in_window_s = (offset_s < 32'd32);

    // Register select and error classification for the current request.
    always_comb begin
        acc_err_s      = 1'b1;
        sel_msip_s     = 1'b0;
        sel_cmp_lo_s   = 1'b0;
        sel_cmp_hi_s   = 1'b0;
        sel_mtime_lo_s = 1'b0;
        sel_mtime_hi_s = 1'b0;
`ifdef BRQ_CLINT_PRESCALER_EN
        sel_prescale_s = 1'b0;
`endif
        if (in_window_s && (offset_s[1:0] == 2'b00)) begin
            case (offset_s[4:0])
                OffMsip: begin
                    sel_msip_s = 1'b1;
                    acc_err_s  = 1'b0;
                end
                OffMtimecmpL: begin
                    sel_cmp_lo_s = 1'b1;
                    acc_err_s    = 1'b0;
                end
                OffMtimecmpH: begin
                    sel_cmp_hi_s = 1'b1;
                    acc_err_s    = 1'b0;
                end
                OffMtimeL: begin
                    sel_mtime_lo_s = 1'b1;
                    acc_err_s      = 1'b0;
                end
                OffMtimeH: begin
                    sel_mtime_hi_s = 1'b1;
                    acc_err_s      = 1'b0;
                end
`ifdef BRQ_CLINT_PRESCALER_EN
                OffPrescale: begin
                    sel_prescale_s = 1'b1;
                    acc_err_s      = 1'b0;
                end
`endif
                default: begin
                    acc_err_s = 1'b1;
                end
            endcase
        end else begin
            acc_err_s = 1'b1;
        end
    end

    // Requests seen while in reset are granted but otherwise ignored.
    assign valid_s = data_req_i & ~rst_i & ~acc_err_s;
    assign wr_s    = valid_s & data_we_i;
    assign rd_s    = valid_s & ~data_we_i;

    // -----------------------------------------------------------------
    // Optional prescaler
    // -----------------------------------------------------------------
`ifdef BRQ_CLINT_PRESCALER_EN
    logic [15:0] prescale_r;
    logic [15:0] tick_cnt_r;
    logic [15:0] prescale_nxt_s;

    assign prescale_nxt_s[7:0]  = data_be_i[0] ? data_wdata_i[7:0]  : prescale_r[7:0];
    assign prescale_nxt_s[15:8] = data_be_i[1] ? data_wdata_i[15:8] : prescale_r[15:8];
    assign tick_s               = (tick_cnt_r == prescale_r);

    // Prescale register and 0..PRESCALE tick counter; a PRESCALE write restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescale_r <= 16'h0000;
            tick_cnt_r <= 16'h0000;
        end else if (wr_s && sel_prescale_s) begin
            prescale_r <= prescale_nxt_s;
            tick_cnt_r <= 16'h0000;
        end else if (tick_s) begin
            tick_cnt_r <= 16'h0000;
        end else begin
            tick_cnt_r <= tick_cnt_r + 16'd1;
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    // -----------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------
    // Selected register value for a read in this cycle.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (sel_msip_s) begin
            rd_data_s = {31'h0000_0000, msip_r};
        end else if (sel_cmp_lo_s) begin
            rd_data_s = mtimecmp_r[31:0];
        end else if (sel_cmp_hi_s) begin
            rd_data_s = mtimecmp_r[63:32];
        end else if (sel_mtime_lo_s) begin
            rd_data_s = mtime_r[31:0];
        end else if (sel_mtime_hi_s) begin
            rd_data_s = shadow_r;
`ifdef BRQ_CLINT_PRESCALER_EN
        end else if (sel_prescale_s) begin
            rd_data_s = {16'h0000, prescale_r};
`endif
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // -----------------------------------------------------------------
    // mtime next value: a bus write wins over the tick in the same cycle,
    // so the written value is what is visible afterwards.
    // -----------------------------------------------------------------
    // Next mtime from write, increment (wrapping at 2^64) or hold.
    always_comb begin
        mtime_nxt_s = mtime_r;
        if (wr_s && sel_mtime_lo_s) begin
            mtime_nxt_s[31:0] = merge_lanes(mtime_r[31:0], data_wdata_i, data_be_i);
        end else if (wr_s && sel_mtime_hi_s) begin
            mtime_nxt_s[63:32] = merge_lanes(mtime_r[63:32], data_wdata_i, data_be_i);
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // mtime register and the HI shadow captured on every MTIME_LO read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_r  <= 64'h0000_0000_0000_0000;
            shadow_r <= 32'h0000_0000;
        end else begin
            mtime_r <= mtime_nxt_s;
            if (rd_s && sel_mtime_lo_s) begin
                shadow_r <= mtime_r[63:32];
            end
        end
    end

    // Software interrupt pending bit and timer compare value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            msip_r     <= 1'b0;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (wr_s && sel_msip_s && data_be_i[0]) begin
                msip_r <= data_wdata_i[0];
            end
            if (wr_s && sel_cmp_lo_s) begin
                mtimecmp_r[31:0] <= merge_lanes(mtimecmp_r[31:0], data_wdata_i, data_be_i);
            end
            if (wr_s && sel_cmp_hi_s) begin
                mtimecmp_r[63:32] <= merge_lanes(mtimecmp_r[63:32], data_wdata_i, data_be_i);
            end
        end
    end

    // Level timer interrupt, one cycle behind the mtime/mtimecmp state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_timer_r <= 1'b0;
        end else begin
            irq_timer_r <= (mtime_r >= mtimecmp_r);
        end
    end

    // Bus response: every granted request outside reset answers next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= 32'h0000_0000;
        end else begin
            rvalid_r <= data_req_i;
            err_r    <= data_req_i & acc_err_s;
            rdata_r  <= rd_s ? rd_data_s : 32'h0000_0000;
        end
    end

    // Responses and the timer interrupt are masked while rst_i is high so a
    // response that was already registered when reset arrives is dropped.
    assign data_gnt_o     = data_req_i;
    assign data_rvalid_o  = rvalid_r & ~rst_i;
    assign data_err_o     = err_r & ~rst_i;
    assign data_rdata_o   = rdata_r & {32{~rst_i}};
    assign irq_timer_o    = irq_timer_r & ~rst_i;
    assign irq_software_o = msip_r;

endmodule
